// File: rtl/dx_stage_latch_if.sv
// D/X stage bundle: F/D side inputs, DX register outputs and stall status.
// master drives the F/D side, slave is the pipeline register.
interface dx_stage_latch_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      fd_insn;
  logic [31:0]      fd_pc;
  logic [31:0]      reg_a;
  logic [31:0]      reg_b;
  logic             flush;
  logic             md_busy;
  logic [31:0]      dx_insn;
  logic [31:0]      dx_pc;
  logic [31:0]      dx_a;
  logic [31:0]      dx_b;
  logic             stall_fd;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fd_insn, fd_pc, reg_a, reg_b,
    output flush, md_busy,
    input  dx_insn, dx_pc, dx_a, dx_b,
    input  stall_fd, stall_cnt
  );

  modport slave (
    input  fd_insn, fd_pc, reg_a, reg_b,
    input  flush, md_busy,
    output dx_insn, dx_pc, dx_a, dx_b,
    output stall_fd, stall_cnt
  );
endinterface

// File: rtl/dx_stage_latch.sv
// D/X pipeline register with load-use bubble insertion,
// multdiv freeze and a saturating stall-cycle counter.
module dx_stage_latch #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int          CNT_W = 16
) (
  input logic           clock,
  input logic           reset,
  dx_stage_latch_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;

  state_t           state;
  logic [31:0]      insnQ;
  logic [31:0]      pcQ;
  logic [31:0]      aQ;
  logic [31:0]      bQ;
  logic [CNT_W-1:0] cntQ;

  logic [4:0] fdOp;
  logic [4:0] fdRd;
  logic [4:0] fdRs;
  logic [4:0] fdRt;
  logic [4:0] dxOp;
  logic [4:0] dxRd;

  assign fdOp = bus.fd_insn[31:27];
  assign fdRd = bus.fd_insn[26:22];
  assign fdRs = bus.fd_insn[21:17];
  assign fdRt = bus.fd_insn[16:12];
  assign dxOp = insnQ[31:27];
  assign dxRd = insnQ[26:22];

  logic useRs;
  logic useRt;
  logic useRd;

  // sw data (rd) comes through the M/W bypass, so only rs is a source
  always_comb begin
    useRs = 1'b0;
    useRt = 1'b0;
    useRd = 1'b0;
    unique case (1'b1)
      fdOp == OP_R: begin
        useRs = 1'b1;
        useRt = 1'b1;
      end
      fdOp == OP_ADDI,
      fdOp == OP_LW,
      fdOp == OP_SW: useRs = 1'b1;
      fdOp == OP_BNE,
      fdOp == OP_BLT: begin
        useRd = 1'b1;
        useRs = 1'b1;
      end
      fdOp == OP_JR: useRd = 1'b1;
      default: ;
    endcase
  end

  logic loadUse;
  logic stallFd;

  assign loadUse = (dxOp == OP_LW) && (dxRd != 5'd0) &&
                   ((useRs && fdRs == dxRd) ||
                    (useRt && fdRt == dxRd) ||
                    (useRd && fdRd == dxRd));

  always_comb begin
    stallFd = 1'b0;
    if (!reset && !bus.flush)
      stallFd = bus.md_busy || (loadUse && state == RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      insnQ <= NOP;
      pcQ   <= '0;
      aQ    <= '0;
      bQ    <= '0;
      cntQ  <= '0;
    end else begin
      if (bus.flush) begin
        state <= RUN;
        insnQ <= NOP;
        pcQ   <= bus.fd_pc;
        aQ    <= '0;
        bQ    <= '0;
      end else if (bus.md_busy) begin
        state <= HOLD;
      end else if (loadUse && state == RUN) begin
        state <= BUBBLE;
        insnQ <= NOP;
        pcQ   <= bus.fd_pc;
        aQ    <= '0;
        bQ    <= '0;
      end else begin
        state <= RUN;
        insnQ <= bus.fd_insn;
        pcQ   <= bus.fd_pc;
        aQ    <= bus.reg_a;
        bQ    <= bus.reg_b;
      end
      if (stallFd && cntQ != {CNT_W{1'b1}})
        cntQ <= cntQ + 1'b1;
    end
  end

  assign bus.dx_insn   = insnQ;
  assign bus.dx_pc     = pcQ;
  assign bus.dx_a      = aQ;
  assign bus.dx_b      = bQ;
  assign bus.stall_fd  = stallFd;
  assign bus.stall_cnt = cntQ;

endmodule

// File: tb/tb_dx_stage_latch.sv
// Randomized check of dx_stage_latch against a rule-level model,
// with directed load-use, flush, hold, reset and saturation cases.
module tb_dx_stage_latch;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;

  logic clock;
  logic reset;

  dx_stage_latch_if #(.CNT_W(16)) ifa ();
  dx_stage_latch_if #(.CNT_W(4))  ifb ();

  dx_stage_latch #(.CNT_W(16)) u0 (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  dx_stage_latch #(.CNT_W(4)) u1 (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // model: DX contents plus whether load-use detection is live
  logic [31:0] mInsn, mPc, mA, mB;
  bit          pcKnown;
  bit          luLive;
  int          mCnt, mCnt4;

  function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  function automatic bit reads(input logic [31:0] insn, input logic [4:0] r);
    logic [4:0] op, rd, rs, rt;
    op = insn[31:27]; rd = insn[26:22];
    rs = insn[21:17]; rt = insn[16:12];
    if (r == 5'd0) return 0;
    if (op == OP_R) return rs == r || rt == r;
    if (op == OP_ADDI || op == OP_LW || op == OP_SW) return rs == r;
    if (op == OP_BNE || op == OP_BLT) return rd == r || rs == r;
    if (op == OP_JR) return rd == r;
    return 0;
  endfunction

  task automatic modelReset();
    mInsn = 32'h0; mPc = 32'h0; mA = 32'h0; mB = 32'h0;
    pcKnown = 1; luLive = 1; mCnt = 0; mCnt4 = 0;
  endtask

  task automatic checkDx();
    chk("dx_insn", ifa.dx_insn, mInsn);
    chk("dx_a", ifa.dx_a, mA);
    chk("dx_b", ifa.dx_b, mB);
    if (pcKnown) chk("dx_pc", ifa.dx_pc, mPc);
    chk("stall_cnt", {16'h0, ifa.stall_cnt}, mCnt);
    chk("stall_cnt4", {28'h0, ifb.stall_cnt}, mCnt4);
    chk("dx_insn4", ifb.dx_insn, mInsn);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    modelReset();
    chk("rst_stall", {31'h0, ifa.stall_fd}, 32'h0);
    checkDx();
  endtask

  task automatic step(input logic [31:0] insn, pc, a, b,
                      input logic fl, md);
    bit lu, expStall;
    @(negedge clock);
    ifa.fd_insn = insn; ifb.fd_insn = insn;
    ifa.fd_pc = pc;     ifb.fd_pc = pc;
    ifa.reg_a = a;      ifb.reg_a = a;
    ifa.reg_b = b;      ifb.reg_b = b;
    ifa.flush = fl;     ifb.flush = fl;
    ifa.md_busy = md;   ifb.md_busy = md;
    reset = 1'b0;
    lu = luLive && mInsn[31:27] == OP_LW && reads(insn, mInsn[26:22]);
    expStall = fl ? 1'b0 : (md ? 1'b1 : lu);
    #1;
    chk("stall_fd", {31'h0, ifa.stall_fd}, {31'h0, expStall});
    chk("stall_fd4", {31'h0, ifb.stall_fd}, {31'h0, expStall});
    @(posedge clock);
    if (fl) begin
      mInsn = 32'h0; mA = 32'h0; mB = 32'h0;
      pcKnown = 0; luLive = 1;
    end else if (md) begin
      luLive = 0;
    end else if (lu) begin
      mInsn = 32'h0; mA = 32'h0; mB = 32'h0;
      mPc = pc; pcKnown = 1; luLive = 0;
    end else begin
      mInsn = insn; mPc = pc; mA = a; mB = b;
      pcKnown = 1; luLive = 1;
    end
    if (expStall) begin
      if (mCnt < 65535) mCnt++;
      if (mCnt4 < 15) mCnt4++;
    end
    #1;
    checkDx();
  endtask

  logic [31:0] lw3, add4, sw3, lw0, add0, w;
  logic [4:0]  ops[8];
  int          holdLeft;
  bit          fl, md;

  initial begin
    reset = 1'b1;
    ifa.fd_insn = '0; ifa.fd_pc = '0; ifa.reg_a = '0; ifa.reg_b = '0;
    ifa.flush = 1'b0; ifa.md_busy = 1'b0;
    ifb.fd_insn = '0; ifb.fd_pc = '0; ifb.reg_a = '0; ifb.reg_b = '0;
    ifb.flush = 1'b0; ifb.md_busy = 1'b0;
    modelReset();
    doReset();

    lw3  = mk(OP_LW, 5'd3, 5'd1, 5'd0);
    add4 = 32'h0106_2000;
    sw3  = mk(OP_SW, 5'd3, 5'd5, 5'd0);
    lw0  = mk(OP_LW, 5'd0, 5'd1, 5'd0);
    add0 = mk(OP_R, 5'd4, 5'd0, 5'd2);

    // load-use: one bubble then the add
    step(lw3, 32'h100, 32'h11, 32'h22, 0, 0);
    step(add4, 32'h104, 32'h33, 32'h44, 0, 0);
    chk("lu_bubble", ifa.dx_insn, 32'h0);
    step(add4, 32'h104, 32'h33, 32'h44, 0, 0);
    chk("lu_add", ifa.dx_insn, add4);
    chk("lu_cnt", {16'h0, ifa.stall_cnt}, 32'd1);

    // no false stalls
    step(lw3, 32'h108, 0, 0, 0, 0);
    step(sw3, 32'h10c, 0, 0, 0, 0);
    chk("sw_nostall", ifa.dx_insn, sw3);
    step(lw0, 32'h110, 0, 0, 0, 0);
    step(add0, 32'h114, 0, 0, 0, 0);
    chk("r0_nostall", ifa.dx_insn, add0);

    // flush beats load-use
    step(lw3, 32'h118, 0, 0, 0, 0);
    step(add4, 32'h11c, 5, 6, 1, 0);
    chk("flush_cnt", {16'h0, ifa.stall_cnt}, 32'd1);

    // multdiv hold for five cycles
    step(add4, 32'h120, 32'h77, 32'h88, 0, 0);
    for (int i = 0; i < 5; i++)
      step($urandom, $urandom, $urandom, $urandom, 0, 1);
    chk("hold_insn", ifa.dx_insn, add4);
    chk("hold_cnt", {16'h0, ifa.stall_cnt}, 32'd6);
    step(lw3, 32'h124, 32'h9, 32'ha, 0, 0);

    // saturation on the narrow counter
    for (int i = 0; i < 20; i++)
      step(add4, 32'h128, 0, 0, 0, 1);
    chk("sat4", {28'h0, ifb.stall_cnt}, 32'd15);

    // async reset mid-hold, then normal load
    doReset();
    chk("rst_stall_md", {31'h0, ifb.stall_fd}, 32'h0);
    step(add4, 32'h200, 32'h1, 32'h2, 0, 0);
    chk("rst_load", ifa.dx_insn, add4);

    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR, 5'b11111};
    holdLeft = 0;
    for (int n = 0; n < 3000; n++) begin
      w = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) w[31:27] = OP_LW;
      w[11:0] = 12'($urandom);
      if (holdLeft > 0) begin
        md = 1; holdLeft--;
      end else begin
        md = 0;
        if ($urandom_range(0, 11) == 0) holdLeft = $urandom_range(1, 6);
      end
      fl = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        doReset();
        holdLeft = 0;
      end
      step(w, $urandom, $urandom, $urandom, fl, md);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
